// File: rtl/cordic_pkg.sv
// Shared types and constants for the rotation-mode CORDIC sine/cosine engine.
package cordic_pkg;

  localparam int unsigned CORDIC_W = 32;

  typedef logic signed [CORDIC_W-1:0] q2_30_t;

  // Pre-scaled start vector so the CORDIC gain cancels out after all micro-rotations.
  localparam q2_30_t K_INV   = 32'h26DD3B6A;
  localparam q2_30_t HALF_PI = 32'h6487ED51;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StDone
  } cordic_state_e;

endpackage

// File: rtl/cordic_sincos_atan.sv
// Arctangent ROM: atan(2^-idx) in signed Q2.30, rounded to nearest.
module cordic_sincos_atan (
  input  logic [4:0]  idx_i,
  output logic [31:0] atan_o
);

  always_comb begin
    atan_o = 32'h0000_0000;
    case (idx_i)
      5'd0:  atan_o = 32'h3243F6A9;
      5'd1:  atan_o = 32'h1DAC6705;
      5'd2:  atan_o = 32'h0FADBAFD;
      5'd3:  atan_o = 32'h07F56EA7;
      5'd4:  atan_o = 32'h03FEAB77;
      5'd5:  atan_o = 32'h01FFD55C;
      5'd6:  atan_o = 32'h00FFFAAB;
      5'd7:  atan_o = 32'h007FFF55;
      5'd8:  atan_o = 32'h003FFFEB;
      5'd9:  atan_o = 32'h001FFFFD;
      5'd10: atan_o = 32'h00100000;
      5'd11: atan_o = 32'h00080000;
      5'd12: atan_o = 32'h00040000;
      5'd13: atan_o = 32'h00020000;
      5'd14: atan_o = 32'h00010000;
      5'd15: atan_o = 32'h00008000;
      5'd16: atan_o = 32'h00004000;
      5'd17: atan_o = 32'h00002000;
      5'd18: atan_o = 32'h00001000;
      5'd19: atan_o = 32'h00000800;
      5'd20: atan_o = 32'h00000400;
      5'd21: atan_o = 32'h00000200;
      5'd22: atan_o = 32'h00000100;
      5'd23: atan_o = 32'h00000080;
      5'd24: atan_o = 32'h00000040;
      5'd25: atan_o = 32'h00000020;
      5'd26: atan_o = 32'h00000010;
      5'd27: atan_o = 32'h00000008;
      5'd28: atan_o = 32'h00000004;
      5'd29: atan_o = 32'h00000002;
      5'd30: atan_o = 32'h00000001;
      default: atan_o = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: one micro-rotation per cycle through a single
// shared x/y/z adder set, yielding cos/sin of a signed Q2.30 angle.
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int unsigned N_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] theta,
  output logic        ready,
  output logic        out_valid,
  output logic [31:0] cos_o,
  output logic [31:0] sin_o,
  output logic        range_err
);

  localparam logic [4:0] LastIdx = 5'(N_ITER - 1);

  cordic_state_e state_q, state_d;
  q2_30_t        x_q, x_d, y_q, y_d, z_q, z_d;
  logic [4:0]    i_q, i_d;
  logic          oor_q, oor_d;
  q2_30_t        cos_q, cos_d, sin_q, sin_d;
  logic          rerr_q, rerr_d;
  logic          valid_q, valid_d;

  logic [31:0]   atan_val;
  q2_30_t        x_sh, y_sh, x_rot, y_rot, z_rot;
  q2_30_t        theta_s;

  cordic_sincos_atan u_atan (
    .idx_i  (i_q),
    .atan_o (atan_val)
  );

  assign theta_s = theta;
  assign ready   = (state_q != StIter);

  // Single micro-rotation; direction follows the sign of the residual angle.
  always_comb begin
    x_sh = x_q >>> i_q;
    y_sh = y_q >>> i_q;
    if (z_q[31]) begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + q2_30_t'(atan_val);
    end else begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - q2_30_t'(atan_val);
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    oor_d   = oor_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    rerr_d  = rerr_q;
    valid_d = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StIter;
          x_d     = K_INV;
          y_d     = '0;
          z_d     = theta_s;
          i_d     = 5'd0;
          oor_d   = (theta_s > HALF_PI) || (theta_s < -HALF_PI);
        end else begin
          state_d = StIdle;
        end
      end
      StIter: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        i_d = i_q + 5'd1;
        if (i_q == LastIdx) begin
          state_d = StDone;
          cos_d   = x_rot;
          sin_d   = y_rot;
          rerr_d  = oor_q;
          valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= 5'd0;
      oor_q   <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
      rerr_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      oor_q   <= oor_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      rerr_q  <= rerr_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign cos_o     = cos_q;
  assign sin_o     = sin_q;
  assign range_err = rerr_q;

endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos against a real-valued sin/cos reference.
module tb_cordic_sincos;

  localparam int  NIter     = 32;
  localparam int  Tol       = 16;
  localparam int  MaxWait   = 100;
  localparam int  HalfPiInt = 1686629713;
  localparam real Q30       = 1073741824.0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] theta;
  logic        ready;
  logic        out_valid;
  logic [31:0] cos_o;
  logic [31:0] sin_o;
  logic        range_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cordic_sincos #(
    .N_ITER (NIter)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .theta     (theta),
    .ready     (ready),
    .out_valid (out_valid),
    .cos_o     (cos_o),
    .sin_o     (sin_o),
    .range_err (range_err)
  );

  task automatic check_val(input string tag, input longint got, input longint exp,
                           input longint tol);
    longint diff;
    diff = got - exp;
    n_checks++;
    if (diff > tol || diff < -tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic longint to_q30(input real v);
    real s;
    s = v * Q30;
    if (s >= 0.0) return longint'($rtoi(s + 0.5));
    else          return -longint'($rtoi(-s + 0.5));
  endfunction

  // One operation: accept, optional ignored mid-ITER start pulse, then result checks.
  task automatic run_op(input string tag, input logic [31:0] th, input bit chk_vals,
                        input int mid_pulse);
    int  lat;
    bit  seen;
    int  thi;
    bit  exp_rerr;
    real a;
    thi      = $signed(th);
    exp_rerr = (thi > HalfPiInt) || (thi < -HalfPiInt);
    a        = $itor(thi) / Q30;

    @(negedge clk);
    theta = th;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    theta = $urandom();
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < MaxWait) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        if (lat == 5) check_val({tag, "_rdy_iter"}, ready, 0, 0);
        if (lat == mid_pulse) begin
          start = 1'b1;
          theta = ~th;
        end
      end
    end
    check_val({tag, "_latency"}, lat, NIter, 0);
    if (seen) begin
      if (chk_vals) begin
        check_val({tag, "_cos"}, $signed(cos_o), to_q30($cos(a)), Tol);
        check_val({tag, "_sin"}, $signed(sin_o), to_q30($sin(a)), Tol);
      end
      check_val({tag, "_rerr"}, range_err, exp_rerr, 0);
      check_val({tag, "_rdy_done"}, ready, 1, 0);
      @(negedge clk);
      check_val({tag, "_one_pulse"}, out_valid, 0, 0);
      if (chk_vals) check_val({tag, "_cos_hold"}, $signed(cos_o), to_q30($cos(a)), Tol);
    end
  endtask

  initial begin
    int q[$];
    int cyc;
    int pulses;
    logic [31:0] th;

    rst   = 1'b1;
    start = 1'b0;
    theta = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", ready, 1, 0);
    check_val("rst_valid", out_valid, 0, 0);
    check_val("rst_cos", cos_o, 0, 0);
    check_val("rst_sin", sin_o, 0, 0);
    check_val("rst_rerr", range_err, 0, 0);
    rst = 1'b0;

    run_op("zero", 32'h00000000, 1'b1, -1);
    run_op("pi_4", 32'h3243F6A9, 1'b1, -1);
    run_op("neg_pi_6", 32'hDE7D5B8E, 1'b1, -1);
    run_op("pi_2", 32'h6487ED51, 1'b1, -1);
    run_op("neg_pi_2", 32'h9B7812AF, 1'b1, -1);
    run_op("over_pi_2", 32'h6487ED52, 1'b0, -1);
    run_op("under_neg_pi_2", 32'h9B7812AE, 1'b0, -1);

    for (int k = 0; k < 8; k++) begin
      th = $urandom_range(32'hC90FDAA2, 0) - 32'h6487ED51;
      run_op($sformatf("rand%0d", k), th, 1'b1, -1);
    end

    run_op("mid_pulse", 32'h1A2B3C4D, 1'b1, 10);

    // start held high: each DONE cycle re-accepts
    @(negedge clk);
    theta = 32'h3243F6A9;
    start = 1'b1;
    cyc   = 0;
    repeat (110) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (out_valid) q.push_back(cyc);
    end
    start = 1'b0;
    check_val("held_pulses", q.size(), 3, 0);
    if (q.size() >= 3) begin
      check_val("held_gap0", q[1] - q[0], NIter + 1, 0);
      check_val("held_gap1", q[2] - q[1], NIter + 1, 0);
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_val("held_drain_ready", ready, 1, 0);

    // leave non-zero outputs and a set flag, then abort the next op mid-ITER
    run_op("flag_before_abort", 32'h80000000, 1'b0, -1);
    @(negedge clk);
    theta = 32'h2000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_valid", out_valid, 0, 0);
    check_val("abort_cos", cos_o, 0, 0);
    check_val("abort_sin", sin_o, 0, 0);
    check_val("abort_rerr", range_err, 0, 0);
    check_val("abort_ready", ready, 1, 0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check_val("abort_no_pulse", pulses, 0, 0);

    // reset wins over a simultaneous start
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    theta = 32'h1000_0000;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check_val("rst_vs_start_ready", ready, 1, 0);

    run_op("after_abort", 32'hF0000000, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
